// File: rtl/rnd_pkg.sv
// rnd_pkg: FSM state encoding, LFSR tap positions and default seed shared by the rnd_arbiter slice.
package rnd_pkg;
    typedef enum logic [1:0] {IDLE, GEN, DELIVER} rnd_state_t;
    localparam int RND_TAP_A = 32;
    localparam int RND_TAP_B = 22;
    localparam int RND_TAP_C = 2;
    localparam int RND_TAP_D = 1;
    localparam logic [31:0] RND_INIT_VAL = 32'hF1928374;
endpackage

// File: rtl/rnd_lfsr_step.sv
// rnd_lfsr_step: Fibonacci LFSR (taps 32,22,2,1) with shift enable and a load that never accepts zero.
module rnd_lfsr_step
    import rnd_pkg::*;
#(
    parameter int LEN = 32,
    parameter int W = 8,
    parameter logic [LEN-1:0] INIT_VAL = LEN'(RND_INIT_VAL)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           shift_en,
    input  logic           load,
    input  logic [LEN-1:0] load_val,
    output logic [W-1:0]   next_word
);
    logic [LEN-1:0] q;
    logic [LEN-1:0] q_next;
    assign q_next = {q[LEN-2:0], q[RND_TAP_A-1] ^ q[RND_TAP_B-1] ^ q[RND_TAP_C-1] ^ q[RND_TAP_D-1]};
    assign next_word = q_next[W-1:0];
    always_ff @(posedge clk) begin
        if (reset) q <= INIT_VAL;
        else if (load) q <= (load_val == '0) ? INIT_VAL : load_val;
        else if (shift_en) q <= q_next;
    end
endmodule

// File: rtl/rnd_arbiter.sv
// rnd_arbiter: round-robin share of one LFSR; each grant shifts WIDTH fresh bits and returns a tagged pulse.
// Define RND_RESEED_EN to add the seed_load/seed_val reseed ports.
module rnd_arbiter
    import rnd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int LFSR_LEN = 32,
    parameter logic [LFSR_LEN-1:0] INIT_VAL = LFSR_LEN'(RND_INIT_VAL)
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef RND_RESEED_EN
    input  logic                    seed_load,
    input  logic [LFSR_LEN-1:0]     seed_val,
`endif
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         grant,
    output logic                    rnd_valid,
    output logic [WIDTH-1:0]        rnd_data,
    output logic [$clog2(NREQ)-1:0] rnd_id,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH) + 1;

    rnd_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IDW-1:0] last, pick;
    logic found, shift, take, reseed;
    logic [LFSR_LEN-1:0] load_val;
    logic [WIDTH-1:0] next_word;

`ifdef RND_RESEED_EN
    assign reseed = seed_load;
    assign load_val = seed_val;
`else
    assign reseed = 1'b0;
    assign load_val = '0;
`endif

    rnd_lfsr_step #(.LEN(LFSR_LEN), .W(WIDTH), .INIT_VAL(INIT_VAL)) u_lfsr (
        .clk(clk),
        .reset(reset),
        .shift_en(shift),
        .load(reseed),
        .load_val(load_val),
        .next_word(next_word)
    );

    // first requester after the last one granted, wrapping around
    always_comb begin
        found = 1'b0;
        pick = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[IDW'((int'(last) + i) % NREQ)]) begin
                found = 1'b1;
                pick = IDW'((int'(last) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        shift = 1'b0;
        take = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GEN;
                    take = 1'b1;
                    cnt_n = '0;
                end
            end
            GEN: begin
                shift = 1'b1;
                cnt_n = cnt + CW'(1);
                if (!req[rnd_id]) state_n = IDLE;
                else if (cnt == CW'(WIDTH - 1)) state_n = DELIVER;
            end
            DELIVER: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // a reseed wins over shifting and over starting or finishing a transaction
        if (reseed) begin
            state_n = IDLE;
            shift = 1'b0;
            take = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            last <= IDW'(NREQ - 1);
            grant <= '0;
            rnd_valid <= 1'b0;
            rnd_data <= '0;
            rnd_id <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            busy <= state_n != IDLE;
            rnd_valid <= state_n == DELIVER;
            if (take) begin
                grant <= NREQ'(1) << pick;
                rnd_id <= pick;
                last <= pick;
            end else if (state_n == IDLE) begin
                grant <= '0;
            end
            if (state == GEN && state_n == DELIVER) rnd_data <= next_word;
        end
    end
endmodule

// File: tb/tb_rnd_arbiter.sv
// tb_rnd_arbiter: directed scenarios for rnd_arbiter against a transaction-level model plus hand-computed words.
// Scenario 6 runs only when RND_RESEED_EN is defined.
module tb_rnd_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 8;
    localparam logic [31:0] INIT = 32'hF1928374;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic seed_load = 1'b0;
    logic [31:0] seed_val = '0;
    logic [NREQ-1:0] grant;
    logic rnd_valid;
    logic [WIDTH-1:0] rnd_data;
    logic [1:0] rnd_id;
    logic busy;

    int vectors = 0;
    int miscompares = 0;
    logic armed = 1'b0;

    rnd_arbiter dut (
        .clk(clk),
        .reset(reset),
`ifdef RND_RESEED_EN
        .seed_load(seed_load),
        .seed_val(seed_val),
`endif
        .req(req),
        .grant(grant),
        .rnd_valid(rnd_valid),
        .rnd_data(rnd_data),
        .rnd_id(rnd_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: owner is the served requester (-1 when idle), age counts cycles since grant
    logic [31:0] m_lfsr;
    int m_owner, m_age, m_last, m_id;
    logic m_valid;
    logic [7:0] m_data;

    always @(posedge clk) begin
        if (reset) begin
            m_lfsr = INIT;
            m_owner = -1;
            m_age = 0;
            m_last = NREQ - 1;
            m_id = 0;
            m_valid = 1'b0;
            m_data = '0;
        end
`ifdef RND_RESEED_EN
        else if (seed_load) begin
            m_lfsr = (seed_val == 0) ? INIT : seed_val;
            m_owner = -1;
            m_valid = 1'b0;
        end
`endif
        else if (m_owner < 0) begin
            m_valid = 1'b0;
            for (int k = 1; k <= NREQ; k++)
                if (m_owner < 0 && req[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_id = m_owner;
                m_age = 1;
            end
        end else if (m_age <= WIDTH) begin
            m_lfsr = step(m_lfsr);
            if (!req[m_owner]) m_owner = -1;
            else begin
                m_age++;
                if (m_age > WIDTH) begin
                    m_valid = 1'b1;
                    m_data = m_lfsr[7:0];
                end
            end
        end else begin
            m_owner = -1;
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("busy", 32'(busy), 32'(m_owner >= 0));
            check("rnd_valid", 32'(rnd_valid), 32'(m_valid));
            check("rnd_id", 32'(rnd_id), 32'(m_id));
            if (m_valid) check("rnd_data", 32'(rnd_data), 32'(m_data));
        end
    end

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int n, output logic [7:0] d, output logic [1:0] id);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rnd_valid && n < bound);
        if (!rnd_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_valid: no rnd_valid within %0d cycles at %0t", bound, $time);
        end
        d = rnd_data;
        id = rnd_id;
    endtask

    int n, cnt;
    logic [7:0] d, s;
    logic [1:0] id;
    logic [7:0] words [5] = '{8'hF9, 8'h7F, 8'h1B, 8'hAC, 8'h07};
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        // model pins
        check("model_step_1", step(32'h1), 32'h3);
        s = step(step(step(step(step(step(step(step(INIT))))))))[7:0];
        check("model_first_word", 32'(s), 32'hF9);

        do_reset();
        armed = 1'b1;
        check("reset_grant", 32'(grant), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(rnd_valid), 0);
        check("reset_data", 32'(rnd_data), 0);
        check("reset_id", 32'(rnd_id), 0);

        // 1: single requester, latency and first word
        req = 4'b0001;
        @(negedge clk);
        check("s1_grant", 32'(grant), 32'h1);
        check("s1_busy", 32'(busy), 1);
        wait_valid(20, n, d, id);
        req = '0;
        check("s1_latency", n + 1, 9);
        check("s1_id", 32'(id), 0);
        check("s1_data", 32'(d), 32'hF9);
        @(negedge clk);
        check("s1_valid_pulse", 32'(rnd_valid), 0);

        // 2: all requesting, round-robin order and spacing
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_valid(30, n, d, id);
            check("s2_id", 32'(id), 32'(order[k]));
            check("s2_word", 32'(d), 32'(words[k]));
            check("s2_period", n, (k == 0) ? 9 : 10);
        end
        req = '0;

        // 3: two requesters together, then a lone one
        do_reset();
        req = 4'b0101;
        wait_valid(30, n, d, id);
        check("s3_first", 32'(id), 0);
        req = 4'b0100;
        wait_valid(30, n, d, id);
        check("s3_second", 32'(id), 2);
        req = '0;
        repeat (2) @(negedge clk);
        req = 4'b0001;
        wait_valid(30, n, d, id);
        check("s3_lone", 32'(id), 0);
        req = '0;

        // 4: abort during GEN
        @(negedge clk) req = 4'b0001;
        repeat (3) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("s4_busy", 32'(busy), 0);
        check("s4_grant", 32'(grant), 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (rnd_valid) cnt++;
        end
        check("s4_no_valid", cnt, 0);
        req = 4'b0010;
        @(negedge clk);
        check("s4_grant1", 32'(grant), 32'h2);
        wait_valid(30, n, d, id);
        check("s4_id", 32'(id), 1);
        req = '0;

        // 5: reset mid-GEN
        @(negedge clk) req = 4'b0001;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("s5_grant", 32'(grant), 0);
        check("s5_busy", 32'(busy), 0);
        reset = 1'b0;
        wait_valid(30, n, d, id);
        check("s5_data", 32'(d), 32'hF9);
        check("s5_latency", n, 9);
        req = '0;

`ifdef RND_RESEED_EN
        // 6: zero reseed aborts and restores INIT, seed 1 gives its own word
        @(negedge clk) req = 4'b0001;
        repeat (3) @(negedge clk);
        seed_load = 1'b1;
        seed_val = 32'h0;
        @(negedge clk) seed_load = 1'b0;
        check("s6_busy", 32'(busy), 0);
        check("s6_grant", 32'(grant), 0);
        wait_valid(30, n, d, id);
        check("s6_init_word", 32'(d), 32'hF9);
        req = '0;
        @(negedge clk) begin
            seed_load = 1'b1;
            seed_val = 32'h1;
        end
        @(negedge clk) begin
            seed_load = 1'b0;
            req = 4'b0001;
        end
        wait_valid(30, n, d, id);
        check("s6_seed1_word", 32'(d), 32'hB6);
        req = '0;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
